// File: rtl/fifoctrl_mc_pkg.sv
// fifoctrl_mc shared constants and helpers.
// Sticky error flags are built only with FIFOCTRL_MC_ERRFLAG_EN defined.
package fifoctrl_mc_pkg;

   localparam int ADDRBIT_D = 4;
   localparam int CHBIT_D   = 2;
   localparam int AFTHRES_D = 12;

   typedef logic [CHBIT_D-1:0] ch_t;

   function automatic int len_of(input int addrbit);
      return 1 << addrbit;
   endfunction

   function automatic int nch_of(input int chbit);
      return 1 << chbit;
   endfunction

endpackage

// File: rtl/fifoctrl_chan.sv
// One logical channel: pointers, fill level, flags, sticky errors.
// FIFOCTRL_MC_ERRFLAG_EN enables the ovf/udf registers.
import fifoctrl_mc_pkg::*;

module fifoctrl_chan #(
   parameter int ADDRBIT = ADDRBIT_D,
   parameter int AFTHRES = AFTHRES_D
) (
   input  logic               clk,
   input  logic               rst_,
   input  logic               wr_en,
   input  logic               rd_en,
   output logic [ADDRBIT-1:0] wrptr,
   output logic [ADDRBIT-1:0] rdptr,
   output logic [ADDRBIT:0]   len,
   output logic               full,
   output logic               afull,
   output logic               notempty,
   output logic               ovf,
   output logic               udf
);

   localparam int LENGTH = len_of(ADDRBIT);

   logic wr_ok;
   logic rd_ok;

   assign full     = (len == (ADDRBIT+1)'(LENGTH));
   assign afull    = (len >= (ADDRBIT+1)'(AFTHRES));
   assign notempty = (len != '0);
   assign wr_ok    = wr_en & ~full;
   assign rd_ok    = rd_en & notempty;

   // Simultaneous accepted read and write leave len unchanged
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         wrptr <= '0;
         rdptr <= '0;
         len   <= '0;
      end else begin
         if (wr_ok)
            wrptr <= wrptr + 1'b1;
         if (rd_ok)
            rdptr <= rdptr + 1'b1;
         if (wr_ok & ~rd_ok)
            len <= len + 1'b1;
         else if (rd_ok & ~wr_ok)
            len <= len - 1'b1;
      end
   end

`ifdef FIFOCTRL_MC_ERRFLAG_EN
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else begin
         if (wr_en & full)
            ovf <= 1'b1;
         if (rd_en & ~notempty)
            udf <= 1'b1;
      end
   end
`else
   assign ovf = 1'b0;
   assign udf = 1'b0;
`endif

endmodule

// File: rtl/fifoctrl_mc.sv
// Multi-channel FIFO controller over one shared, channel-partitioned RAM.
// Define FIFOCTRL_MC_ERRFLAG_EN to get sticky ovf/udf flags.
import fifoctrl_mc_pkg::*;

module fifoctrl_mc #(
   parameter int ADDRBIT = ADDRBIT_D,
   parameter int CHBIT   = CHBIT_D,
   parameter int AFTHRES = AFTHRES_D
) (
   input  logic                     clk,
   input  logic                     rst_,
   input  logic                     fifowr,
   input  logic [CHBIT-1:0]         wr_ch,
   input  logic                     fiford,
   input  logic [CHBIT-1:0]         rd_ch,
   input  logic [CHBIT-1:0]         len_ch,
   output logic                     write,
   output logic [CHBIT+ADDRBIT-1:0] wraddr,
   output logic                     read,
   output logic [CHBIT+ADDRBIT-1:0] rdaddr,
   output logic [nch_of(CHBIT)-1:0] fifofull,
   output logic [nch_of(CHBIT)-1:0] afull,
   output logic [nch_of(CHBIT)-1:0] notempty,
   output logic [ADDRBIT:0]         fifolen,
   output logic [nch_of(CHBIT)-1:0] ovf,
   output logic [nch_of(CHBIT)-1:0] udf
);

   localparam int NCH = nch_of(CHBIT);

   logic [ADDRBIT-1:0] wrptr [NCH];
   logic [ADDRBIT-1:0] rdptr [NCH];
   logic [ADDRBIT:0]   len   [NCH];

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      fifoctrl_chan #(
         .ADDRBIT (ADDRBIT),
         .AFTHRES (AFTHRES)
      ) u_chan (
         .clk      (clk),
         .rst_     (rst_),
         .wr_en    (fifowr && (wr_ch == CHBIT'(c))),
         .rd_en    (fiford && (rd_ch == CHBIT'(c))),
         .wrptr    (wrptr[c]),
         .rdptr    (rdptr[c]),
         .len      (len[c]),
         .full     (fifofull[c]),
         .afull    (afull[c]),
         .notempty (notempty[c]),
         .ovf      (ovf[c]),
         .udf      (udf[c])
      );
   end

   assign write   = fifowr & ~fifofull[wr_ch];
   assign read    = fiford & notempty[rd_ch];
   assign wraddr  = {wr_ch, wrptr[wr_ch]};
   assign rdaddr  = {rd_ch, rdptr[rd_ch]};
   assign fifolen = len[len_ch];

endmodule

// File: doc/fifoctrl_mc.md
# fifoctrl_mc

Multi-channel FIFO controller: manages NCH independent logical FIFOs of LENGTH entries each, sharing one external dual-port memory of NCH*LENGTH words partitioned by channel. Produces per-channel write/read pointers, fill levels, full/almost-full/not-empty flags, and gated memory strobes. Sits between channelised packet/word sources (e.g. per-lane hash input queues) and a single shared RAM, replacing one-controller-per-channel instantiation.

## Interface
- ADDRBIT, 4, per-channel pointer width; LENGTH = 2**ADDRBIT entries per channel
- CHBIT, 2, channel index width; NCH = 2**CHBIT channels
- AFTHRES, 12, almost-full threshold, 1..LENGTH
- clk  in  1  clock; all state on rising edge
- rst_  in  1  reset, asynchronous, active-low
- fifowr  in  1  write request
- wr_ch  in  CHBIT  channel of write request
- fiford  in  1  read request
- rd_ch  in  CHBIT  channel of read request
- len_ch  in  CHBIT  channel whose length appears on fifolen
- write  out  1  memory write enable (fifowr & !fifofull[wr_ch])
- wraddr  out  CHBIT+ADDRBIT  {wr_ch, wrptr[wr_ch]}
- read  out  1  memory read enable (fiford & notempty[rd_ch])
- rdaddr  out  CHBIT+ADDRBIT  {rd_ch, rdptr[rd_ch]}
- fifofull  out  NCH  per-channel full (len == LENGTH)
- afull  out  NCH  per-channel len >= AFTHRES
- notempty  out  NCH  per-channel len != 0
- fifolen  out  ADDRBIT+1  length of channel len_ch
- ovf  out  NCH  sticky: write attempted while full (macro-gated)
- udf  out  NCH  sticky: read attempted while empty (macro-gated)

## Operation
- Per channel: wrptr, rdptr (ADDRBIT bits, wrap modulo LENGTH), len (ADDRBIT+1 bits, 0..LENGTH).
- write/read, wraddr/rdaddr, all flags, fifolen: combinational from current state and inputs.
- On edge: write increments wrptr[wr_ch]; read increments rdptr[rd_ch].
- len update per channel c: +1 if write to c only; -1 if read from c only; unchanged if both or neither.
- Same channel read and write same cycle: both accepted if allowed; when full, write blocked and read accepted (len -1); when empty, read blocked and write accepted (len +1). No write-through: read data is the old entry at rdptr.
- Different channels same cycle: independent, both proceed.
- Pointers wrap LENGTH-1 -> 0 without affecting len.
- Blocked requests change no state except sticky flags.
- Memory has fixed read latency owned by the RAM; controller asserts read on the address cycle only.

## Timing
- Reset (rst_ low, async): all pointers, len, ovf, udf -> 0; outputs: notempty=0, fifofull=0, afull=0, fifolen=0, write/read follow gating (read=0, write=fifowr). Reset mid-operation discards all contents immediately.
- Flag latency: flags reflect an accepted access one cycle after the access edge.
- Full after exactly LENGTH writes with no reads; notempty rises the cycle after first write.
- afull uses >=; AFTHRES=LENGTH makes afull equal fifofull.

## Configuration
- FIFOCTRL_MC_ERRFLAG_EN defined: ovf[c] sets on fifowr & wr_ch==c & fifofull[c]; udf[c] sets on fiford & rd_ch==c & !notempty[c]; both hold until rst_.
- Undefined: no flag registers; ovf and udf tied to 0.

## Structure
- Package fifoctrl_mc_pkg: default ADDRBIT/CHBIT/AFTHRES constants, derived LENGTH/NCH functions, channel-index typedef.
- Sub-module fifoctrl_chan: one channel's wrptr/rdptr/len/flags/sticky bits, inputs wr_en/rd_en already decoded; instantiated NCH times via generate. Top does channel decode, gating, address concatenation, fifolen mux.

## Test plan
- Reset then write ch1 16 times (ADDRBIT=4) -> fifofull[1]=1, afull[1] from 12th write, other channels notempty=0, wraddr 0x10..0x1F.
- 17th write to full ch1 -> write=0, len stays 16, ovf[1]=1 (macro on) / 0 (off).
- Full ch1, simultaneous read+write ch1 -> read=1, write=0, len 15 next cycle.
- Empty ch2, simultaneous read+write ch2 -> write=1, read=0, len 1, udf[2]=1 with macro.
- Fill/drain ch3 40 words with mixed traffic -> pointers wrap 15->0, rdaddr sequence matches write order, len ends 0.
- rst_ low mid-traffic asynchronously (between edges) -> all len/flags 0 immediately, next write goes to address {ch,0}.
